// File: rtl/shift_add_mult_ctrl_if.sv
// Operand/product handshake between the operand source, the multiplier
// and the product consumer.
interface shift_add_mult_ctrl_if #(
   parameter int unsigned WIDTH = 32
);
   logic               start;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic               busy;
   logic               done;
   logic [2*WIDTH-1:0] product;

   modport master (output start, a, b, input busy, done, product);
   modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/shift_add_mult_ctrl.sv
// Sequential unsigned WIDTHxWIDTH multiplier: one shared prefix adder, one
// add-and-shift per cycle, fixed latency of WIDTH iterations.
module prefix_adder #(
   parameter int unsigned W = 32
) (
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout
);
   logic [W-1:0] hx, g, p, gn, pn;
   logic [W:0]   c;

   // Kogge-Stone prefix tree; cin folds in after the group generate/propagate.
   always_comb begin
      hx = x ^ y;
      g  = x & y;
      p  = hx;
      gn = '0;
      pn = '0;
      for (int unsigned d = 1; d < W; d = d * 2) begin
         gn = g;
         pn = p;
         for (int unsigned i = d; i < W; i++) begin
            gn[i] = g[i] | (p[i] & g[i-d]);
            pn[i] = p[i] & p[i-d];
         end
         g = gn;
         p = pn;
      end
      c    = {g | (p & {W{cin}}), cin};
      sum  = hx ^ c[W-1:0];
      cout = c[W];
   end
endmodule

module shift_add_mult_ctrl #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   shift_add_mult_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t               state, state_nx;
   logic [WIDTH-1:0]     mcand, acc, mq, addend, sum;
   logic                 cout;
   logic [CNT_W-1:0]     cnt;
   logic [2*WIDTH-1:0]   product_q;
   logic [2*WIDTH-1:0]   step;

   assign addend = mq[0] ? mcand : '0;

   prefix_adder #(.W(WIDTH)) u_add (
      .x    (acc),
      .y    (addend),
      .cin  (1'b0),
      .sum  (sum),
      .cout (cout)
   );

   // Carry-out becomes the new acc MSB; the low multiplier bit is consumed.
   assign step = {cout, sum, mq[WIDTH-1:1]};

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.start) state_nx = RUN;
         RUN:     if (cnt == '1) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mcand     <= '0;
         acc       <= '0;
         mq        <= '0;
         cnt       <= '0;
         product_q <= '0;
      end else begin
         case (state)
            IDLE: if (bus.start) begin
               mcand <= bus.a;
               mq    <= bus.b;
               acc   <= '0;
               cnt   <= '0;
            end
            RUN: begin
               {acc, mq} <= step;
               cnt       <= cnt + 1'b1;
               if (cnt == '1) product_q <= step;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy    = (state == RUN);
   assign bus.done    = (state == DONE);
   assign bus.product = product_q;
endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Randomised and directed bench for shift_add_mult_ctrl against a timing /
// arithmetic model that tracks cycles since the accepting edge.
module tb_shift_add_mult_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;
   bit   chk_en = 1'b0;

   shift_add_mult_ctrl_if #(.WIDTH(32)) bus ();

   shift_add_mult_ctrl #(.WIDTH(32), .CNT_W(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // Model: ph counts cycles since acceptance (0 = idle, 1..32 busy, 33 done).
   int          ph = 0;
   logic [63:0] pend = '0;
   logic [63:0] m_prod = '0;

   always @(posedge clk) begin
      if (rst) begin
         ph = 0;
         m_prod = '0;
      end else if (ph == 0) begin
         if (bus.start) begin
            ph = 1;
            pend = 64'(bus.a) * 64'(bus.b);
         end
      end else if (ph == 32) begin
         ph = 33;
         m_prod = pend;
      end else if (ph == 33) begin
         ph = 0;
      end else begin
         ph++;
      end
      chk_en = 1'b1;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", 64'(bus.busy), 64'(ph >= 1 && ph <= 32));
         chk("done", 64'(bus.done), 64'(ph == 33));
         chk("product", bus.product, m_prod);
         chk("busy_and_done", 64'(bus.busy & bus.done), 64'd0);
      end
   end

   function automatic logic [31:0] pick();
      int unsigned r = $urandom_range(0, 7);
      if (r == 0) return '0;
      if (r == 1) return '1;
      return $urandom;
   endfunction

   // One directed operation; checks latency and a hand-computed product.
   task automatic run_op(input logic [31:0] av, input logic [31:0] bv,
                         input logic [63:0] exp, input string name);
      int k = 0;
      bit seen = 1'b0;
      @(posedge clk); #1;
      bus.start = 1'b1; bus.a = av; bus.b = bv;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom;
      while (!seen && k < 40) begin
         @(negedge clk);
         k++;
         if (bus.done) seen = 1'b1;
      end
      if (!seen) begin
         chk({name, "_timeout"}, 64'd0, 64'd1);
      end else begin
         chk({name, "_latency"}, 64'(k), 64'd33);
         chk({name, "_lit"}, bus.product, exp);
      end
   endtask

   initial begin
      bus.start = 1'b0; bus.a = '0; bus.b = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_busy", 64'(bus.busy), 64'd0);
      chk("reset_done", 64'(bus.done), 64'd0);
      chk("reset_product", bus.product, 64'd0);

      run_op(32'd3, 32'd5, 64'h0000_0000_0000_000F, "basic");
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "carry");
      run_op(32'd0, 32'h1234_5678, 64'd0, "zero");
      run_op(32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000, "msb");

      // start held high with changing operands: only edges at N, N+34 accept
      @(posedge clk); #1;
      for (int unsigned i = 0; i < 75; i++) begin
         bus.start = 1'b1; bus.a = pick(); bus.b = pick();
         @(posedge clk); #1;
      end
      bus.start = 1'b0;
      repeat (40) @(posedge clk);

      // reset in N+15 of a running operation
      #1 bus.start = 1'b1; bus.a = 32'd7; bus.b = 32'd9;
      @(posedge clk); #1 bus.start = 1'b0;
      repeat (14) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("midrst_busy", 64'(bus.busy), 64'd0);
      chk("midrst_product", bus.product, 64'd0);
      run_op(32'd2, 32'd2, 64'd4, "after_rst");

      // back-to-back random regression with occasional start gaps and resets
      @(posedge clk); #1;
      for (int unsigned i = 0; i < 34000; i++) begin
         bus.start = ($urandom_range(0, 9) != 0);
         bus.a = pick(); bus.b = pick();
         rst = ($urandom_range(0, 1999) == 0);
         @(posedge clk); #1;
      end
      rst = 1'b0; bus.start = 1'b0;
      repeat (40) @(posedge clk);
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
